// File: rtl/revo_phase_lock_controller_pkg.sv
// Shared encodings for the revo phase-lock controller: FSM states, the four
// legal leading-edge patterns and their BUFGMUX select mapping.
package revo_constants;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_FAKE    = 2'd3
    } state_e;

    localparam logic [3:0] PAT_P000 = 4'b1111;
    localparam logic [3:0] PAT_P090 = 4'b1110;
    localparam logic [3:0] PAT_P180 = 4'b1100;
    localparam logic [3:0] PAT_P270 = 4'b1000;

    function automatic logic pat_is_valid(input logic [3:0] pat);
        logic ok;
        case (pat)
            PAT_P000, PAT_P090, PAT_P180, PAT_P270: ok = 1'b1;
            default:                                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Later the edge lands in the word, later the 127 MHz phase we select.
    function automatic logic [1:0] pat_to_sel(input logic [3:0] pat);
        logic [1:0] sel;
        case (pat)
            PAT_P000: sel = 2'b00;
            PAT_P090: sel = 2'b01;
            PAT_P180: sel = 2'b10;
            PAT_P270: sel = 2'b11;
            default:  sel = 2'b00;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/revo_phase_lock_controller_word_watchdog.sv
// 16-bit word counter with clear and enable; expire_o is high for the single
// word in which the count sits at TERMINAL, and the count wraps to zero there.
module word_watchdog #(
    parameter int unsigned TERMINAL = 2047
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [15:0] TC = 16'(TERMINAL);

    logic [15:0] count_q, count_d;
    logic        at_tc;

    assign at_tc = (count_q == TC);

    // Expire ignores clr_i on purpose; callers gate it so a clearing event
    // in the terminal word wins without creating a combinational loop.
    assign expire_o = en_i & at_tc;

    always_comb begin
        count_d = count_q;
        if (clr_i)
            count_d = '0;
        else if (en_i)
            count_d = at_tc ? 16'd0 : count_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count_q <= '0;
        else
            count_q <= count_d;
    end

endmodule

// File: rtl/revo_phase_lock_controller.sv
// Revolution-marker phase lock: confirms a stable sub-word edge position,
// drives the BUFGMUX phase select and falls back to a local fake revo.
module revo_phase_lock_controller
    import revo_constants::*;
#(
    parameter int unsigned CONFIRM_COUNT = 3,
    parameter int unsigned TIMEOUT_WORDS = 2048,
    parameter int unsigned FAKE_PERIOD   = 1280
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] pulse_stream,
    input  logic       enable_fake,
    input  logic       unlock_request,
    output logic [1:0] select2,
    output logic [3:0] select4,
    output logic       phase_locked,
    output logic       fake_mode,
    output logic       revo_out,
    output logic [7:0] mismatch_count
);

    localparam logic [3:0] CC = 4'(CONFIRM_COUNT);

    state_e     state_q, state_d;
    logic [3:0] cand_q, cand_d;
    logic [3:0] match_q, match_d;
    logic [3:0] match_inc;
    logic [1:0] sel2_q, sel2_d;
    logic [3:0] sel4_q, sel4_d;
    logic       revo_q, revo_d;
    logic       locked_q, fake_q;
    logic [7:0] mis_q;
    logic       mis_inc;

    logic       wd_clr, wd_en, wd_exp;
    logic       fp_clr, fp_en, fp_exp;
    logic       pat_valid, pat_nonzero, do_lock;

    assign pat_valid   = pat_is_valid(pulse_stream);
    assign pat_nonzero = |pulse_stream;
    assign match_inc   = match_q + 4'd1;

    // FAKE owns its own period counter; the watchdog is parked at zero there
    // so a relock from FAKE starts with a full timeout window.
    assign wd_en = (state_q != ST_FAKE);
    assign fp_en = (state_q == ST_FAKE);
    assign fp_clr = (state_q != ST_FAKE);

    word_watchdog #(.TERMINAL(TIMEOUT_WORDS - 1)) u_watchdog (
        .clk      (clock),
        .rst_n    (reset_n),
        .clr_i    (wd_clr | (state_q == ST_FAKE)),
        .en_i     (wd_en),
        .expire_o (wd_exp)
    );

    word_watchdog #(.TERMINAL(FAKE_PERIOD - 1)) u_fake_period (
        .clk      (clock),
        .rst_n    (reset_n),
        .clr_i    (fp_clr),
        .en_i     (fp_en),
        .expire_o (fp_exp)
    );

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        match_d = match_q;
        sel2_d  = sel2_q;
        sel4_d  = sel4_q;
        revo_d  = 1'b0;
        mis_inc = 1'b0;
        wd_clr  = 1'b0;
        do_lock = 1'b0;

        if (unlock_request) begin
            // Unlock discards any coincident word, so nothing is counted.
            state_d = ST_HUNT;
            match_d = '0;
            wd_clr  = 1'b1;
        end else begin
            case (state_q)
                ST_HUNT, ST_FAKE: begin
                    if (pat_valid) begin
                        cand_d  = pulse_stream;
                        match_d = 4'd1;
                        wd_clr  = 1'b1;
                        if (CC == 4'd1)
                            do_lock = 1'b1;
                        else
                            state_d = ST_CONFIRM;
                    end else begin
                        mis_inc = pat_nonzero;
                        if (state_q == ST_HUNT) begin
                            if (wd_exp && enable_fake)
                                state_d = ST_FAKE;
                        end else if (!enable_fake) begin
                            state_d = ST_HUNT;
                        end else if (fp_exp) begin
                            revo_d = 1'b1;
                        end
                    end
                end

                ST_CONFIRM: begin
                    if (pat_valid) begin
                        wd_clr = 1'b1;
                        if (pulse_stream == cand_q) begin
                            match_d = match_inc;
                            if (match_inc == CC)
                                do_lock = 1'b1;
                        end else begin
                            mis_inc = 1'b1;
                            cand_d  = pulse_stream;
                            match_d = 4'd1;
                        end
                    end else begin
                        mis_inc = pat_nonzero;
                        if (wd_exp) begin
                            state_d = enable_fake ? ST_FAKE : ST_HUNT;
                            match_d = '0;
                        end
                    end
                end

                ST_LOCKED: begin
                    if (pat_nonzero && pulse_stream == sel4_q) begin
                        revo_d = 1'b1;
                        wd_clr = 1'b1;
                    end else begin
                        mis_inc = pat_nonzero;
                        if (wd_exp) begin
                            state_d = enable_fake ? ST_FAKE : ST_HUNT;
                            match_d = '0;
                        end
                    end
                end

                default: state_d = ST_HUNT;
            endcase
        end

        // The clock-tree select moves only here, together with the lock revo.
        if (do_lock) begin
            state_d = ST_LOCKED;
            sel2_d  = pat_to_sel(pulse_stream);
            sel4_d  = pulse_stream;
            revo_d  = 1'b1;
            match_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_HUNT;
            cand_q   <= '0;
            match_q  <= '0;
            sel2_q   <= '0;
            sel4_q   <= '0;
            revo_q   <= 1'b0;
            locked_q <= 1'b0;
            fake_q   <= 1'b0;
            mis_q    <= '0;
        end else begin
            state_q  <= state_d;
            cand_q   <= cand_d;
            match_q  <= match_d;
            sel2_q   <= sel2_d;
            sel4_q   <= sel4_d;
            revo_q   <= revo_d;
            locked_q <= (state_d == ST_LOCKED);
            fake_q   <= (state_d == ST_FAKE);
            if (mis_inc && mis_q != 8'hFF)
                mis_q <= mis_q + 8'd1;
        end
    end

    assign select2        = sel2_q;
    assign select4        = sel4_q;
    assign phase_locked   = locked_q;
    assign fake_mode      = fake_q;
    assign revo_out       = revo_q;
    assign mismatch_count = mis_q;

endmodule

// File: tb/tb_revo_phase_lock_controller.sv
// Directed bench for the revo phase-lock controller with hand-derived
// expectations at each step.
module tb_revo_phase_lock_controller;

    logic       clock;
    logic       reset_n;
    logic [3:0] pulse_stream;
    logic       enable_fake;
    logic       unlock_request;
    logic [1:0] select2;
    logic [3:0] select4;
    logic       phase_locked;
    logic       fake_mode;
    logic       revo_out;
    logic [7:0] mismatch_count;

    int tests;
    int fails;
    int n;

    revo_phase_lock_controller dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .pulse_stream   (pulse_stream),
        .enable_fake    (enable_fake),
        .unlock_request (unlock_request),
        .select2        (select2),
        .select4        (select4),
        .phase_locked   (phase_locked),
        .fake_mode      (fake_mode),
        .revo_out       (revo_out),
        .mismatch_count (mismatch_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic word(input logic [3:0] p, input logic u);
        @(negedge clock);
        pulse_stream   = p;
        unlock_request = u;
        @(posedge clock);
        #1;
        pulse_stream   = 4'b0000;
        unlock_request = 1'b0;
    endtask

    task automatic idle(input int cnt);
        repeat (cnt) @(posedge clock);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset_n        = 1'b0;
        pulse_stream   = 4'b0000;
        enable_fake    = 1'b0;
        unlock_request = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_select2", 32'(select2), 32'h0);
        chk("rst_select4", 32'(select4), 32'h0);
        chk("rst_locked", 32'(phase_locked), 32'h0);
        chk("rst_fake", 32'(fake_mode), 32'h0);
        chk("rst_revo", 32'(revo_out), 32'h0);
        chk("rst_mismatch", 32'(mismatch_count), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        idle(2);

        // 1100 three times, 100 idle words apart -> lock at 180 deg
        word(4'b1100, 1'b0);
        chk("b1_locked", 32'(phase_locked), 32'h0);
        idle(100);
        word(4'b1100, 1'b0);
        chk("b2_locked", 32'(phase_locked), 32'h0);
        idle(100);
        word(4'b1100, 1'b0);
        chk("b3_locked", 32'(phase_locked), 32'h1);
        chk("b3_revo", 32'(revo_out), 32'h1);
        chk("b3_select2", 32'(select2), 32'h2);
        chk("b3_select4", 32'(select4), 32'hC);
        chk("b3_mismatch", 32'(mismatch_count), 32'h0);
        idle(1);
        chk("b3_revo_single", 32'(revo_out), 32'h0);

        // Invalid word while locked
        word(4'b0110, 1'b0);
        chk("c_mismatch", 32'(mismatch_count), 32'h1);
        chk("c_revo", 32'(revo_out), 32'h0);
        chk("c_select2", 32'(select2), 32'h2);
        chk("c_locked", 32'(phase_locked), 32'h1);

        word(4'b1100, 1'b0);
        chk("d_revo", 32'(revo_out), 32'h1);

        // Unlock coincident with a matching word: unlock wins
        word(4'b1100, 1'b1);
        chk("e_locked", 32'(phase_locked), 32'h0);
        chk("e_revo", 32'(revo_out), 32'h0);
        chk("e_mismatch", 32'(mismatch_count), 32'h1);
        chk("e_select2", 32'(select2), 32'h2);

        // Candidate replacement: match restarts at 1
        word(4'b1110, 1'b0);
        word(4'b1110, 1'b0);
        word(4'b1000, 1'b0);
        chk("f_mismatch", 32'(mismatch_count), 32'h2);
        chk("f_locked0", 32'(phase_locked), 32'h0);
        chk("f_select2_hold", 32'(select2), 32'h2);
        word(4'b1000, 1'b0);
        chk("f_locked1", 32'(phase_locked), 32'h0);
        word(4'b1000, 1'b0);
        chk("f_locked2", 32'(phase_locked), 32'h1);
        chk("f_select2", 32'(select2), 32'h3);
        chk("f_select4", 32'(select4), 32'h8);
        chk("f_revo", 32'(revo_out), 32'h1);

        // Lock on 1111, let the watchdog expire into FAKE
        enable_fake = 1'b1;
        word(4'b0000, 1'b1);
        word(4'b1111, 1'b0);
        word(4'b1111, 1'b0);
        word(4'b1111, 1'b0);
        chk("g_locked", 32'(phase_locked), 32'h1);
        chk("g_select2", 32'(select2), 32'h0);
        n = 0;
        while (!fake_mode && n < 5000) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("g_fake_entry_words", 32'(n), 32'd2048);
        chk("g_fake_locked", 32'(phase_locked), 32'h0);
        chk("g_fake_select2", 32'(select2), 32'h0);
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (!revo_out && n < 5000);
        chk("g_fake_first_revo", 32'(n), 32'd1280);
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (!revo_out && n < 5000);
        chk("g_fake_second_revo", 32'(n), 32'd1280);
        chk("g_fake_still", 32'(fake_mode), 32'h1);
        word(4'b1111, 1'b0);
        chk("g_relock_fake0", 32'(fake_mode), 32'h0);
        chk("g_relock_nolock", 32'(phase_locked), 32'h0);
        word(4'b1111, 1'b0);
        word(4'b1111, 1'b0);
        chk("g_relock", 32'(phase_locked), 32'h1);
        chk("g_relock_fake", 32'(fake_mode), 32'h0);
        chk("g_relock_select2", 32'(select2), 32'h0);
        chk("g_mismatch", 32'(mismatch_count), 32'h2);

        // Saturation: 2 already counted, 253 more reach 255
        for (int i = 0; i < 253; i++) word(4'b0101, 1'b0);
        chk("h_mismatch_255", 32'(mismatch_count), 32'd255);
        for (int i = 0; i < 47; i++) word(4'b0101, 1'b0);
        chk("h_mismatch_sat", 32'(mismatch_count), 32'd255);
        chk("h_locked", 32'(phase_locked), 32'h1);

        // Asynchronous reset mid-stream
        @(negedge clock);
        pulse_stream = 4'b0101;
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        chk("r_locked", 32'(phase_locked), 32'h0);
        chk("r_select2", 32'(select2), 32'h0);
        chk("r_select4", 32'(select4), 32'h0);
        chk("r_mismatch", 32'(mismatch_count), 32'h0);
        chk("r_fake", 32'(fake_mode), 32'h0);
        chk("r_revo", 32'(revo_out), 32'h0);
        pulse_stream = 4'b0000;
        @(negedge clock);
        reset_n = 1'b1;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
